// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port memory front-end arbiter:
// exception codes, FSM state encodings, owner IDs and the round-robin pick.
package mem_port_arbiter_pkg;

  localparam int EXCEPTION_LEN = 4;

  localparam logic [EXCEPTION_LEN-1:0] EXCEP_OK           = 4'h0;
  localparam logic [EXCEPTION_LEN-1:0] EXCEP_MISALIGNED   = 4'h1;
  localparam logic [EXCEPTION_LEN-1:0] EXCEP_ACCESS_FAULT = 4'h2;
  localparam logic [EXCEPTION_LEN-1:0] EXCEP_BUS_TIMEOUT  = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_e;

  // On a tie the requester that was not served last wins.
  function automatic owner_e pick_winner(input logic a_v, input logic b_v,
                                         input owner_e last);
    if (a_v && b_v) begin
      if (last == OWNER_A) return OWNER_B;
      return OWNER_A;
    end
    if (b_v) return OWNER_B;
    return OWNER_A;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and downstream memory-side signals of the arbiter.
// Handshake: a request is pending while *_inputValid_In is high; it is accepted
// only in IDLE, and completes with a single-cycle *_operationOK_Out pulse that
// carries data/exception. Downstream, memAccess_Out stays high with stable
// fields until a cycle with memAccessOK_In high (or the arbiter times out).
interface mem_port_arbiter_if;
  logic [31:0] a_addr_In, b_addr_In;
  logic [31:0] a_data_In, b_data_In;
  logic [1:0]  a_dataWidth_In, b_dataWidth_In;
  logic        a_isRead_In, b_isRead_In;
  logic        a_inputValid_In, b_inputValid_In;
  logic        a_operationOK_Out, b_operationOK_Out;
  logic [31:0] a_data_Out, b_data_Out;
  logic [mem_port_arbiter_pkg::EXCEPTION_LEN-1:0] a_exception_Out, b_exception_Out;
  logic [31:0] memAddr_Out, memData_Out;
  logic [1:0]  memDataWidth_Out;
  logic        memIsRead_Out, memAccess_Out, memAccessOK_In;
  logic [31:0] memData_In;
  logic [mem_port_arbiter_pkg::EXCEPTION_LEN-1:0] memException_In;

  modport master (
    input  a_addr_In, b_addr_In, a_data_In, b_data_In,
           a_dataWidth_In, b_dataWidth_In, a_isRead_In, b_isRead_In,
           a_inputValid_In, b_inputValid_In,
           memAccessOK_In, memData_In, memException_In,
    output a_operationOK_Out, b_operationOK_Out, a_data_Out, b_data_Out,
           a_exception_Out, b_exception_Out,
           memAddr_Out, memData_Out, memDataWidth_Out, memIsRead_Out, memAccess_Out
  );

  modport slave (
    output a_addr_In, b_addr_In, a_data_In, b_data_In,
           a_dataWidth_In, b_dataWidth_In, a_isRead_In, b_isRead_In,
           a_inputValid_In, b_inputValid_In,
           memAccessOK_In, memData_In, memException_In,
    input  a_operationOK_Out, b_operationOK_Out, a_data_Out, b_data_Out,
           a_exception_Out, b_exception_Out,
           memAddr_Out, memData_Out, memDataWidth_Out, memIsRead_Out, memAccess_Out
  );
endinterface

// File: rtl/mem_port_arbiter_bus_timeout_counter.sv
// Cycle counter bounding a downstream access; expired is high in the enabled
// cycle where the count has reached TIMEOUT_CYCLES-1.
module bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = enable && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one downstream memory port between instruction
// fetch (A) and load/store (B); every access is latched and timeout-bounded.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus,
  output arb_state_e         dbg_state_o
);

  arb_state_e state_q, state_d;
  owner_e     owner_q, owner_d;
  owner_e     last_q, last_d;
  owner_e     win;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]  width_q, width_d;
  logic        is_read_q, is_read_d;
  logic [EXCEPTION_LEN-1:0] exc_q, exc_d;
  logic        cnt_clear, cnt_enable, cnt_expired;

  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .expired(cnt_expired)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    width_d    = width_q;
    is_read_d  = is_read_q;
    rdata_d    = rdata_q;
    exc_d      = exc_q;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    win        = pick_winner(bus.a_inputValid_In, bus.b_inputValid_In, last_q);
    unique case (state_q)
      ST_IDLE: begin
        if (bus.a_inputValid_In || bus.b_inputValid_In) begin
          owner_d   = win;
          addr_d    = (win == OWNER_B) ? bus.b_addr_In      : bus.a_addr_In;
          wdata_d   = (win == OWNER_B) ? bus.b_data_In      : bus.a_data_In;
          width_d   = (win == OWNER_B) ? bus.b_dataWidth_In : bus.a_dataWidth_In;
          is_read_d = (win == OWNER_B) ? bus.b_isRead_In    : bus.a_isRead_In;
          cnt_clear = 1'b1;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_enable = 1'b1;
        // A real completion in the expiry cycle takes priority over the timeout.
        if (bus.memAccessOK_In) begin
          rdata_d = bus.memData_In;
          exc_d   = bus.memException_In;
          state_d = ST_RESP;
        end else if (cnt_expired) begin
          rdata_d = '0;
          exc_d   = EXCEP_BUS_TIMEOUT;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        last_d  = owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWNER_A;
      last_q    <= OWNER_B;
      addr_q    <= '0;
      wdata_q   <= '0;
      width_q   <= '0;
      is_read_q <= 1'b0;
      rdata_q   <= '0;
      exc_q     <= EXCEP_OK;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      width_q   <= width_d;
      is_read_q <= is_read_d;
      rdata_q   <= rdata_d;
      exc_q     <= exc_d;
    end
  end

  logic resp_a, resp_b;
  assign resp_a = (state_q == ST_RESP) && (owner_q == OWNER_A);
  assign resp_b = (state_q == ST_RESP) && (owner_q == OWNER_B);

  assign bus.memAccess_Out     = (state_q == ST_BUSY);
  assign bus.memAddr_Out       = addr_q;
  assign bus.memData_Out       = wdata_q;
  assign bus.memDataWidth_Out  = width_q;
  assign bus.memIsRead_Out     = is_read_q;
  assign bus.a_operationOK_Out = resp_a;
  assign bus.b_operationOK_Out = resp_b;
  assign bus.a_data_Out        = resp_a ? rdata_q : '0;
  assign bus.b_data_Out        = resp_b ? rdata_q : '0;
  assign bus.a_exception_Out   = resp_a ? exc_q : EXCEP_OK;
  assign bus.b_exception_Out   = resp_b ? exc_q : EXCEP_OK;
  assign dbg_state_o           = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of single transactions, back-to-back
// alternation, timeout and reset-mid-transaction sequences.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int TO = 4;

  typedef struct packed {
    logic        port;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  width;
    logic        rd;
    logic [31:0] data;
    logic [3:0]  exc;
  } exp_t;

  typedef struct {
    logic        a_v, b_v;
    logic [31:0] a_addr, b_addr;
    logic        a_rd, b_rd;
    int          wait_n;
    logic        silent;
    logic [31:0] rdata;
    logic [3:0]  mexc;
    logic        port;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  arb_state_e dbg_state;
  mem_port_arbiter_if ifc ();

  mem_port_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (ifc),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   start_cyc = 0;
  int   last_lat = 0;
  int   last_acc = 0;
  int   acc_cnt = 0;
  int   ok_log[$];
  exp_t exp_q[$];
  exp_t mon_e;

  int          mem_wait = 0;
  logic        mem_silent = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [3:0]  mem_exc = EXCEP_OK;
  int          busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // downstream memory model: answers after mem_wait BUSY cycles unless silent
  always @(posedge clk) begin
    #1;
    ifc.memData_In      = mem_rdata;
    ifc.memException_In = mem_exc;
    if (ifc.memAccess_Out) begin
      ifc.memAccessOK_In = !mem_silent && (busy_cnt == mem_wait);
      busy_cnt++;
    end else begin
      ifc.memAccessOK_In = 1'b0;
      busy_cnt = 0;
    end
  end

  // scoreboard / monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.a_operationOK_Out || ifc.b_operationOK_Out) begin
        chk("no_access_in_resp", ifc.memAccess_Out, 0);
        chk("single_ok", ifc.a_operationOK_Out & ifc.b_operationOK_Out, 0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_ok: got pulse a=%0b b=%0b expected none (cycle %0d)",
                   ifc.a_operationOK_Out, ifc.b_operationOK_Out, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("owner", ifc.b_operationOK_Out, mon_e.port);
          if (mon_e.port) begin
            chk("b_data", ifc.b_data_Out, mon_e.data);
            chk("b_exc", ifc.b_exception_Out, mon_e.exc);
            chk("a_quiet", {ifc.a_data_Out, 28'd0, ifc.a_exception_Out}, 0);
          end else begin
            chk("a_data", ifc.a_data_Out, mon_e.data);
            chk("a_exc", ifc.a_exception_Out, mon_e.exc);
            chk("b_quiet", {ifc.b_data_Out, 28'd0, ifc.b_exception_Out}, 0);
          end
        end
        last_lat = cyc - start_cyc;
        last_acc = acc_cnt;
        acc_cnt  = 0;
        ok_log.push_back(cyc);
      end else begin
        chk("data_zero_no_ok", {ifc.a_data_Out, ifc.b_data_Out}, 0);
        chk("exc_zero_no_ok", {ifc.a_exception_Out, ifc.b_exception_Out}, 0);
      end
      if (ifc.memAccess_Out) begin
        acc_cnt++;
        if (exp_q.size() != 0) begin
          chk("mem_addr", ifc.memAddr_Out, exp_q[0].addr);
          chk("mem_wdata", ifc.memData_Out, exp_q[0].wdata);
          chk("mem_width", ifc.memDataWidth_Out, exp_q[0].width);
          chk("mem_isread", ifc.memIsRead_Out, exp_q[0].rd);
        end
      end
    end
  end

  // driver tasks
  function automatic vec_t mk(input logic a_v, input logic b_v,
                              input logic [31:0] a_addr, input logic a_rd,
                              input logic [31:0] b_addr, input logic b_rd,
                              input int wait_n, input logic silent,
                              input logic [31:0] rdata, input logic [3:0] mexc,
                              input logic port);
    vec_t v;
    v.a_v = a_v; v.b_v = b_v; v.a_addr = a_addr; v.a_rd = a_rd;
    v.b_addr = b_addr; v.b_rd = b_rd; v.wait_n = wait_n; v.silent = silent;
    v.rdata = rdata; v.mexc = mexc; v.port = port;
    return v;
  endfunction

  function automatic void push_exp(input vec_t v, input logic port);
    exp_t e;
    e.port  = port;
    e.addr  = port ? v.b_addr : v.a_addr;
    e.wdata = port ? (v.b_addr ^ 32'h5A5A_0000) : (v.a_addr ^ 32'hA5A5_0000);
    e.width = port ? 2'd1 : 2'd2;
    e.rd    = port ? v.b_rd : v.a_rd;
    e.data  = v.silent ? 32'h0 : v.rdata;
    e.exc   = v.silent ? EXCEP_BUS_TIMEOUT : v.mexc;
    exp_q.push_back(e);
  endfunction

  task automatic drive_vec(input vec_t v);
    mem_wait   = v.wait_n;
    mem_silent = v.silent;
    mem_rdata  = v.rdata;
    mem_exc    = v.mexc;
    @(posedge clk);
    #1;
    ifc.a_inputValid_In = v.a_v;
    ifc.b_inputValid_In = v.b_v;
    ifc.a_addr_In       = v.a_addr;
    ifc.b_addr_In       = v.b_addr;
    ifc.a_data_In       = v.a_addr ^ 32'hA5A5_0000;
    ifc.b_data_In       = v.b_addr ^ 32'h5A5A_0000;
    ifc.a_dataWidth_In  = 2'd2;
    ifc.b_dataWidth_In  = 2'd1;
    ifc.a_isRead_In     = v.a_rd;
    ifc.b_isRead_In     = v.b_rd;
    start_cyc           = cyc;
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_bound: got %0d pending responses expected 0", exp_q.size());
      exp_q.delete();
    end
    #1;
    ifc.a_inputValid_In = 1'b0;
    ifc.b_inputValid_In = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_mem_access"}, ifc.memAccess_Out, 0);
    chk({tag, "_mem_fields"}, {ifc.memAddr_Out, ifc.memData_Out}, 0);
    chk({tag, "_mem_ctl"}, {ifc.memDataWidth_Out, ifc.memIsRead_Out}, 0);
    chk({tag, "_ok"}, {ifc.a_operationOK_Out, ifc.b_operationOK_Out}, 0);
    chk({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  vec_t vecs[8];
  vec_t v;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.a_inputValid_In = 1'b0; ifc.b_inputValid_In = 1'b0;
    ifc.a_addr_In = '0; ifc.b_addr_In = '0; ifc.a_data_In = '0; ifc.b_data_In = '0;
    ifc.a_dataWidth_In = '0; ifc.b_dataWidth_In = '0;
    ifc.a_isRead_In = 1'b0; ifc.b_isRead_In = 1'b0;
    ifc.memAccessOK_In = 1'b0; ifc.memData_In = '0; ifc.memException_In = EXCEP_OK;

    vecs[0] = mk(1, 0, 32'h0000_0010, 1, 32'h0, 1, 0, 0, 32'h1234_5678, EXCEP_OK, 0);
    vecs[1] = mk(0, 1, 32'h0, 1, 32'h8000_0004, 0, 3, 0, 32'h0000_CAFE, EXCEP_OK, 1);
    vecs[2] = mk(1, 1, 32'h20, 1, 32'h200, 0, 0, 0, 32'h1111_1111, EXCEP_OK, 0);
    vecs[3] = mk(1, 1, 32'h24, 0, 32'h204, 1, 1, 0, 32'h2222_2222, EXCEP_OK, 1);
    vecs[4] = mk(1, 1, 32'h28, 1, 32'h208, 1, 2, 0, 32'h3333_3333, EXCEP_OK, 0);
    vecs[5] = mk(0, 1, 32'h0, 1, 32'h300, 1, 0, 1, 32'hDEAD_BEEF, EXCEP_OK, 1);
    vecs[6] = mk(1, 0, 32'h40, 1, 32'h0, 1, 1, 0, 32'h4444_4444, EXCEP_ACCESS_FAULT, 0);
    vecs[7] = mk(1, 1, 32'h44, 1, 32'h404, 1, 0, 0, 32'h5555_5555, EXCEP_OK, 1);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset");

    // table: one transaction per entry, latency and access length checked
    for (int i = 0; i < 8; i++) begin
      drive_vec(vecs[i]);
      push_exp(vecs[i], vecs[i].port);
      drain(40);
      chk($sformatf("latency_%0d", i), last_lat,
          vecs[i].silent ? TO + 1 : vecs[i].wait_n + 2);
      chk($sformatf("access_cycles_%0d", i), last_acc,
          vecs[i].silent ? TO : vecs[i].wait_n + 1);
    end

    // back-to-back: both held high, grants alternate every 3 cycles
    v = mk(1, 1, 32'h50, 1, 32'h500, 0, 0, 0, 32'h6666_6666, EXCEP_OK, 0);
    ok_log.delete();
    drive_vec(v);
    push_exp(v, 0); push_exp(v, 1); push_exp(v, 0); push_exp(v, 1);
    drain(40);
    chk("b2b_count", ok_log.size(), 4);
    for (int i = 1; i < ok_log.size(); i++)
      chk($sformatf("b2b_spacing_%0d", i), ok_log[i] - ok_log[i-1], 3);

    // A alone so that the last-served bit is A before the reset
    v = mk(1, 0, 32'h60, 1, 32'h0, 1, 0, 0, 32'h7777_7777, EXCEP_OK, 0);
    drive_vec(v);
    push_exp(v, 0);
    drain(40);

    // reset in the second BUSY cycle: no response, request dropped
    v = mk(1, 0, 32'h70, 1, 32'h0, 1, 0, 1, 32'h0, EXCEP_OK, 0);
    drive_vec(v);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ifc.a_inputValid_In = 1'b0;
    @(negedge clk);
    check_reset_values("mid_reset");
    repeat (6) @(posedge clk);
    #1 mem_silent = 1'b0;

    // after reset the tie goes to A again
    v = mk(1, 1, 32'h80, 1, 32'h800, 1, 0, 0, 32'h8888_8888, EXCEP_OK, 0);
    drive_vec(v);
    push_exp(v, 0);
    drain(40);
    chk("post_reset_latency", last_lat, 2);

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
